// File: rtl/uart_hex_dump_if.sv
// Byte-stream and transmitter handshake bundle for uart_hex_dump.
// The DUT side uses the slave modport; the environment uses master.
interface uart_hex_dump_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          in_valid;
  logic [7:0]    in_data;
  logic          tx_busy;
  logic          tx_en;
  logic [7:0]    tx_data;
  logic          overflow;
  logic [LW-1:0] level;
  logic          idle;

  modport master (
    output in_valid, in_data, tx_busy,
    input  tx_en, tx_data, overflow, level, idle
  );

  modport slave (
    input  in_valid, in_data, tx_busy,
    output tx_en, tx_data, overflow, level, idle
  );
endinterface

// File: rtl/uart_hex_dump.sv
// Buffers received bytes and re-emits them as spaced ASCII hex pairs with CR LF line breaks.
// Define UART_HEX_DUMP_ADDR_EN to prefix each line with a 4-digit offset, a colon and a space.
module uart_hex_dump #(
  parameter int BYTES_PER_LINE = 8,
  parameter int FIFO_DEPTH     = 16,
  parameter int UPPERCASE      = 1
) (
  input logic            CLK,
  input logic            RST,
  uart_hex_dump_if.slave bus
);
  // state | meaning
  // IDLE  | nothing in flight; pops a byte once the FIFO has one and tx is free
  // NEXT  | present the character at pos_q and pulse tx_en
  // ACK   | wait for the transmitter to report busy
  // DONE  | wait for busy to drop, then advance position or fetch the next byte
  typedef enum logic [1:0] {S_IDLE, S_NEXT, S_ACK, S_DONE} state_t;

  localparam int         AW       = $clog2(FIFO_DEPTH);
  localparam logic [7:0] LAST_COL = 8'(BYTES_PER_LINE - 1);
  // Positions 0..5 are the offset prefix; they exist only with the offset column.
  localparam logic [3:0] POS_HI   = 4'd6;
  localparam logic [3:0] POS_LO   = 4'd7;
  localparam logic [3:0] POS_SEP  = 4'd8;
  localparam logic [3:0] POS_LF   = 4'd9;

  function automatic logic [7:0] hex_char(input logic [3:0] n, input logic upper);
    if (n < 4'd10)  return 8'h30 + {4'h0, n};
    else if (upper) return 8'h37 + {4'h0, n};
    else            return 8'h57 + {4'h0, n};
  endfunction

  state_t        state_q, state_d;
  logic [3:0]    pos_q, pos_d;
  logic [7:0]    col_q, col_d;
  logic [7:0]    byte_q, byte_d;
  logic [7:0]    txd_q, txd_d;
  logic [7:0]    ch;
  logic          pop, take, tx_en_c;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, overflow_q;

`ifdef UART_HEX_DUMP_ADDR_EN
  logic [15:0]   off_q, off_d;
  logic [15:0]   addr_q, addr_d;
`endif

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push  = bus.in_valid && (!full || pop);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (bus.in_valid && !push) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  always_comb begin
    ch = 8'h20;
    case (pos_q)
`ifdef UART_HEX_DUMP_ADDR_EN
      4'd0:    ch = hex_char(addr_q[15:12], 1'b1);
      4'd1:    ch = hex_char(addr_q[11:8],  1'b1);
      4'd2:    ch = hex_char(addr_q[7:4],   1'b1);
      4'd3:    ch = hex_char(addr_q[3:0],   1'b1);
      4'd4:    ch = 8'h3A;
      4'd5:    ch = 8'h20;
`endif
      POS_HI:  ch = hex_char(byte_q[7:4], UPPERCASE != 0);
      POS_LO:  ch = hex_char(byte_q[3:0], UPPERCASE != 0);
      POS_SEP: ch = (col_q == LAST_COL) ? 8'h0D : 8'h20;
      POS_LF:  ch = 8'h0A;
      default: ch = 8'h20;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      pos_q   <= POS_HI;
      col_q   <= 8'h00;
      byte_q  <= 8'h00;
      txd_q   <= 8'h00;
`ifdef UART_HEX_DUMP_ADDR_EN
      off_q   <= 16'h0000;
      addr_q  <= 16'h0000;
`endif
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      col_q   <= col_d;
      byte_q  <= byte_d;
      txd_q   <= txd_d;
`ifdef UART_HEX_DUMP_ADDR_EN
      off_q   <= off_d;
      addr_q  <= addr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    col_d   = col_q;
    byte_d  = byte_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    take    = 1'b0;
    tx_en_c = 1'b0;
`ifdef UART_HEX_DUMP_ADDR_EN
    off_d   = off_q;
    addr_d  = addr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!empty && !bus.tx_busy) take = 1'b1;
      end
      S_NEXT: begin
        if (!bus.tx_busy) begin
          tx_en_c = 1'b1;
          txd_d   = ch;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (bus.tx_busy) state_d = S_DONE;
      end
      S_DONE: begin
        if (!bus.tx_busy) begin
          if (pos_q == POS_SEP && col_q == LAST_COL) begin
            pos_d   = POS_LF;
            state_d = S_NEXT;
          end else if (pos_q < POS_SEP) begin
            pos_d   = pos_q + 4'd1;
            state_d = S_NEXT;
          end else begin
            col_d = (pos_q == POS_LF) ? 8'h00 : col_q + 8'h01;
            if (!empty) take = 1'b1;
            else        state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (take) begin
      pop     = 1'b1;
      byte_d  = mem[rd_ptr];
      state_d = S_NEXT;
`ifdef UART_HEX_DUMP_ADDR_EN
      addr_d  = off_q;
      off_d   = off_q + 16'h0001;
      pos_d   = (col_d == 8'h00) ? 4'd0 : POS_HI;
`else
      pos_d   = POS_HI;
`endif
    end
  end

  assign bus.tx_en    = tx_en_c;
  assign bus.tx_data  = tx_en_c ? ch : txd_q;
  assign bus.overflow = overflow_q;
  assign bus.level    = count;
  assign bus.idle     = empty && (state_q == S_IDLE);
endmodule

// File: tb/tb_uart_hex_dump.sv
// Directed bench for uart_hex_dump: two instances (defaults; 2 bytes/line, 4-deep, lowercase)
// each driven by a uart_tx-like busy responder.
module tb_uart_hex_dump;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  uart_hex_dump_if #(.FIFO_DEPTH(16)) a_bus ();
  uart_hex_dump_if #(.FIFO_DEPTH(4))  b_bus ();

  uart_hex_dump u_a (.CLK(CLK), .RST(RST), .bus(a_bus));
  uart_hex_dump #(.BYTES_PER_LINE(2), .FIFO_DEPTH(4), .UPPERCASE(0))
    u_b (.CLK(CLK), .RST(RST), .bus(b_bus));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Transmitter responders: busy for 4 cycles starting the cycle after tx_en.
  logic [7:0] a_q[$], b_q[$];
  int a_t[$];
  int a_cnt = 0, b_cnt = 0, a_gate = 0, b_gate = 0;
  logic a_hold = 1'b0, b_hold = 1'b0;
  assign a_bus.tx_busy = a_hold || (a_cnt != 0);
  assign b_bus.tx_busy = b_hold || (b_cnt != 0);

  always @(posedge CLK or posedge RST) begin
    if (RST) a_cnt <= 0;
    else if (a_bus.tx_en) begin
      a_q.push_back(a_bus.tx_data);
      a_t.push_back(cyc);
      if (a_bus.tx_busy) a_gate <= a_gate + 1;
      a_cnt <= 4;
    end else if (a_cnt != 0) a_cnt <= a_cnt - 1;
  end

  always @(posedge CLK or posedge RST) begin
    if (RST) b_cnt <= 0;
    else if (b_bus.tx_en) begin
      b_q.push_back(b_bus.tx_data);
      if (b_bus.tx_busy) b_gate <= b_gate + 1;
      b_cnt <= 4;
    end else if (b_cnt != 0) b_cnt <= b_cnt - 1;
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input int which, input logic [7:0] b);
    @(posedge CLK); #1;
    if (which == 0) begin a_bus.in_valid = 1'b1; a_bus.in_data = b; end
    else            begin b_bus.in_valid = 1'b1; b_bus.in_data = b; end
    @(posedge CLK); #1;
    a_bus.in_valid = 1'b0;
    b_bus.in_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge CLK); #1 RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
    a_q.delete(); b_q.delete(); a_t.delete();
  endtask

  task automatic wait_idle(input int which, input string tag);
    int n = 0;
    logic id;
    id = (which == 0) ? a_bus.idle : b_bus.idle;
    while (!id && n < 3000) begin
      @(posedge CLK); #1;
      n++;
      id = (which == 0) ? a_bus.idle : b_bus.idle;
    end
    chk({tag, "_idle"}, {15'd0, id}, 16'd1);
  endtask

  task automatic check_chars(input int which, input string tag, input string exp);
    logic [7:0] got[$];
    if (which == 0) got = a_q; else got = b_q;
    chk({tag, "_count"}, 16'(got.size()), 16'(exp.len()));
    for (int i = 0; i < exp.len() && i < got.size(); i++)
      chk($sformatf("%s_char%0d", tag, i), {8'h00, got[i]}, {8'h00, exp[i]});
    if (which == 0) a_q.delete(); else b_q.delete();
  endtask

  initial begin
    string pre0, pre2, pre8;
    logic [7:0] first_ch;
`ifdef UART_HEX_DUMP_ADDR_EN
    pre0 = "0000: "; pre2 = "0002: "; pre8 = "0008: "; first_ch = 8'h30;
`else
    pre0 = "";       pre2 = "";       pre8 = "";       first_ch = 8'h34;
`endif
    a_bus.in_valid = 1'b0; a_bus.in_data = 8'h00;
    b_bus.in_valid = 1'b0; b_bus.in_data = 8'h00;

    // Reset values
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_tx_en",    {15'd0, a_bus.tx_en},    16'd0);
    chk("rst_tx_data",  {8'd0, a_bus.tx_data},   16'h0000);
    chk("rst_overflow", {15'd0, a_bus.overflow}, 16'd0);
    chk("rst_level",    {11'd0, a_bus.level},    16'd0);
    chk("rst_idle",     {15'd0, a_bus.idle},     16'd1);
    RST = 1'b0;

    // Single byte 0x4A: latency, spacing, character stream
    @(posedge CLK); #1 a_bus.in_valid = 1'b1; a_bus.in_data = 8'h4A;
    @(posedge CLK); #1 a_bus.in_valid = 1'b0;
    chk("lat_n1_tx_en", {15'd0, a_bus.tx_en}, 16'd0);
    chk("lat_n1_level", {11'd0, a_bus.level}, 16'd1);
    @(posedge CLK); #1;
    chk("lat_n2_tx_en",   {15'd0, a_bus.tx_en}, 16'd1);
    chk("lat_n2_tx_data", {8'd0, a_bus.tx_data}, {8'd0, first_ch});
    chk("lat_n2_level",   {11'd0, a_bus.level}, 16'd0);
    wait_idle(0, "t1");
    chk("t1_spacing01", 16'(a_t[1] - a_t[0]), 16'd6);
    chk("t1_spacing12", 16'(a_t[2] - a_t[1]), 16'd6);
    chk("t1_tx_data_hold", {8'd0, a_bus.tx_data}, 16'h0020);
    check_chars(0, "t1", {pre0, "4A "});

    // Full line 0x00..0x07, then next byte at column 0
    pulse_reset();
    for (int i = 0; i < 8; i++) send(0, 8'(i));
    wait_idle(0, "t2a");
    send(0, 8'h5C);
    wait_idle(0, "t2b");
    check_chars(0, "t2", {pre0, "00 01 02 03 04 05 06 07\015\012", pre8, "5C "});

    // Reset mid-character, then a fresh byte at column 0
    pulse_reset();
    send(0, 8'h01); send(0, 8'h02); send(0, 8'h03);
    @(posedge CLK); #1 RST = 1'b1;
    @(posedge CLK); #1;
    chk("t4_rst_tx_en",    {15'd0, a_bus.tx_en},    16'd0);
    chk("t4_rst_level",    {11'd0, a_bus.level},    16'd0);
    chk("t4_rst_overflow", {15'd0, a_bus.overflow}, 16'd0);
    chk("t4_rst_idle",     {15'd0, a_bus.idle},     16'd1);
    RST = 1'b0;
    a_q.delete(); a_t.delete();
    send(0, 8'h10);
    wait_idle(0, "t4");
    check_chars(0, "t4", {pre0, "10 "});

    // Overflow on the 4-deep instance with the transmitter held busy
    pulse_reset();
    b_hold = 1'b1;
    for (int i = 0; i < 6; i++) send(1, 8'h10 + 8'(i));
    chk("t3_level",    {13'd0, b_bus.level},    16'd4);
    chk("t3_overflow", {15'd0, b_bus.overflow}, 16'd1);
    chk("t3_no_tx",    16'(b_q.size()),         16'd0);
    @(posedge CLK); #1 b_hold = 1'b0;
    wait_idle(1, "t3");
    chk("t3_overflow_sticky", {15'd0, b_bus.overflow}, 16'd1);
    chk("t3_level_empty",     {13'd0, b_bus.level},    16'd0);
    check_chars(1, "t3", {pre0, "10 11\015\012", pre2, "12 13\015\012"});

    // Two bytes per line, offset column when enabled
    pulse_reset();
    send(1, 8'h41); send(1, 8'h42); send(1, 8'h43);
    wait_idle(1, "t5");
    check_chars(1, "t5", {pre0, "41 42\015\012", pre2, "43 "});

    // Lowercase digits
    pulse_reset();
    send(1, 8'hAB);
    wait_idle(1, "t6");
    check_chars(1, "t6", {pre0, "ab "});

    chk("a_tx_en_gate", 16'(a_gate), 16'd0);
    chk("b_tx_en_gate", 16'(b_gate), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_hex_dump.md
# uart_hex_dump

Streaming hex-dump formatter between `uart_rx` and `uart_tx`. Received bytes are buffered in a parametrised FIFO and emitted as ASCII hex pairs. Pairs are separated by a space, and CR LF is inserted after every `BYTES_PER_LINE` bytes. This generalises the single-byte hex echo by adding buffering with overflow detection, line grouping, selectable digit case and an optional offset column.

## Interface

Parameters:
- `BYTES_PER_LINE`, default 8: bytes per output line; range 1..255.
- `FIFO_DEPTH`, default 16: input FIFO entries; power of two, 2..256.
- `UPPERCASE`, default 1: 1 selects "A".."F"; 0 selects "a".."f".

Ports:
- `CLK`, input, 1: single system clock; all logic on its rising edge.
- `RST`, input, 1: reset, asynchronous and active-high.
- `in_valid`, input, 1: one-cycle strobe marking a received byte (`uart_rx_valid`).
- `in_data`, input, 8: received byte; sampled when `in_valid`=1.
- `tx_busy`, input, 1: `uart_tx_busy` from the transmitter.
- `tx_en`, output, 1: one-cycle pulse that starts a character transmission.
- `tx_data`, output, 8: ASCII character; stable from the `tx_en` pulse until the next one.
- `overflow`, output, 1: sticky; set when a byte is dropped because the FIFO is full.
- `level`, output, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `idle`, output, 1: high when the FIFO is empty and the FSM is in IDLE.

## Operation

- **Reset values:**
  - `tx_en`=0, `tx_data`=8'h00, `overflow`=0, `level`=0, `idle`=1.
  - Column counter = 0, offset counter = 0, FSM = IDLE.
  - Asserting `RST` mid-character aborts the character; no partial state survives.
- **FIFO write:**
  - Performed when `in_valid`=1 and the FIFO is not full, or when it is full and a pop happens in the same cycle.
  - Otherwise the byte is dropped and `overflow` is set.
  - Simultaneous push and pop leaves `level` unchanged.
- **Character sequence per byte:**
  - Emit HI nibble, then LO nibble.
  - Then emit SEP: 0x20 if column < `BYTES_PER_LINE`-1; otherwise 0x0D then 0x0A, and the column resets to 0.
- **Nibble mapping:** 0..9 map to 0x30..0x39. 10..15 map to 0x41..0x46 when `UPPERCASE`=1, else 0x61..0x66.
- **FSM states:**
  - IDLE: if FIFO not empty, pop into the byte register and go to NEXT.
  - NEXT: select the next character from the sequence position, drive `tx_data`, pulse `tx_en`, go to ACK.
  - ACK: wait for `tx_busy`=1, then go to DONE.
  - DONE: wait for `tx_busy`=0. Then go to NEXT if characters remain for this byte. Otherwise pop the next byte and go to NEXT if the FIFO is not empty, or go to IDLE.
- **Counter rules:**
  - The column counter is 8 bits and increments after SEP is emitted.
  - The offset counter is 16 bits, increments per byte popped, and wraps FFFF→0000.
- **`tx_en` gating:** `tx_en` is never asserted while `tx_busy`=1.

## Timing

- Latency: `in_valid` in cycle N, with the FIFO empty, FSM in IDLE and `tx_busy`=0 → first `tx_en` in cycle N+2.
- Character spacing is set by `tx_busy`. The next `tx_en` follows the falling edge of `tx_busy` by exactly 1 cycle (DONE→NEXT).
- `level` is updated the cycle after a push or pop.
- `overflow` rises the cycle after the dropped strobe.

## Configuration

- Macro: `UART_HEX_DUMP_ADDR_EN`.
- **Defined:** at column 0, before the first HI nibble of each line, emit a prefix:
  - 4 uppercase hex digits of the offset counter (MSB first), then 0x3A ':' and 0x20.
  - The prefix shows the offset of that line's first byte.
  - The prefix is added as extra sequence positions; the FSM states are unchanged.
- **Undefined:** no prefix is emitted. The offset counter and its sequence logic are not synthesised.

## Test plan

1. Defaults; a single byte 0x4A, with `tx_busy` modelled by `uart_tx` → characters 0x34, 0x41, 0x20; `idle` returns to 1.
2. Defaults; bytes 0x00..0x07 → "00 01 02 03 04 05 06 07" followed by 0x0D 0x0A; the next byte starts at column 0.
3. `FIFO_DEPTH`=4; hold `tx_busy`=1 and push 6 bytes → `level`=4 and `overflow`=1. After release, exactly the first 4 bytes are dumped.
4. Assert `RST` mid-character after pushing 3 bytes → `tx_en`=0, `level`=0, `overflow`=0. The next byte 0x10 yields "10 " at column 0.
5. `UART_HEX_DUMP_ADDR_EN` defined, `BYTES_PER_LINE`=2; bytes 0x41, 0x42, 0x43 → "0000: 41 42" CR LF, then "0002: 43 ".
6. `UPPERCASE`=0; byte 0xAB → 0x61, 0x62, 0x20.
